// File: rtl/vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// vending_ctrl_param
//   Parametrised vending controller with a per-item price table, per-item
//   stock counters, a multi-add cart, cancel, inactivity timeout and restock.
//   Change and refunds are paid out one note per cycle using a greedy
//   largest-denomination-first rule.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   coin           one-hot coin pulse {100,50,20,10,5}
//   start          begin selection (needs non-zero credit)
//   sel_qty        packed per-item quantities, item0 in the LSBs
//   add_more       add sel_qty to the cart this cycle
//   confirm        close the cart and attempt the purchase
//   cancel         abort and refund all money
//   restock_valid  restock strobe, honoured in IDLE only
//   restock_idx    item to restock
//   restock_qty    units to add to that item
//   coin_reject    1-cycle pulse: the last coin was not credited
//   total_amount   credited money
//   total_cost     cost latched when the cart is checked
//   dispense_valid 1-cycle pulse qualifying dispense_qty
//   dispense_qty   packed per-item units dispensed
//   note_valid     one note issued this cycle
//   note_denom     one-hot denomination, same encoding as coin
//   is_refund      qualifies note_valid: 1 refund, 0 change
//   change_total   amount being returned in CHANGE/REFUND
//   busy           controller is not IDLE
// ---------------------------------------------------------------------------
module vending_ctrl_param #(
    parameter int                         N_ITEMS    = 5,
    parameter int                         QTY_W      = 4,
    parameter int                         AMT_W      = 16,
    parameter logic [N_ITEMS*AMT_W-1:0]   PRICES     = {16'd100, 16'd50, 16'd5, 16'd10, 16'd20},
    parameter int                         STOCK_INIT = 9,
    parameter int                         TIMEOUT    = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [4:0]                                        coin,
    input  logic                                              start,
    input  logic [N_ITEMS*QTY_W-1:0]                          sel_qty,
    input  logic                                              add_more,
    input  logic                                              confirm,
    input  logic                                              cancel,
    input  logic                                              restock_valid,
    input  logic [((N_ITEMS > 1) ? $clog2(N_ITEMS) : 1)-1:0]  restock_idx,
    input  logic [QTY_W-1:0]                                  restock_qty,
    output logic                                              coin_reject,
    output logic [AMT_W-1:0]                                  total_amount,
    output logic [AMT_W-1:0]                                  total_cost,
    output logic                                              dispense_valid,
    output logic [N_ITEMS*QTY_W-1:0]                          dispense_qty,
    output logic                                              note_valid,
    output logic [4:0]                                        note_denom,
    output logic                                              is_refund,
    output logic [AMT_W-1:0]                                  change_total,
    output logic                                              busy
);

    localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    // Wide enough that the sum of all cart*price products can never wrap.
    localparam int COST_W = AMT_W + QTY_W + IDX_W + 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_DISPENSE = 3'd3;
    localparam logic [2:0] ST_CHANGE   = 3'd4;
    localparam logic [2:0] ST_REFUND   = 3'd5;

    // Monetary value of a one-hot denomination; anything else is worth 0.
    function automatic logic [AMT_W-1:0] denom_value(input logic [4:0] d);
        logic [AMT_W-1:0] v;
        case (d)
            5'b10000: v = AMT_W'(7'd100);
            5'b01000: v = AMT_W'(6'd50);
            5'b00100: v = AMT_W'(5'd20);
            5'b00010: v = AMT_W'(4'd10);
            5'b00001: v = AMT_W'(3'd5);
            default:  v = '0;
        endcase
        return v;
    endfunction

    // Largest note not exceeding the remaining amount; 0 when nothing fits.
    function automatic logic [4:0] greedy_denom(input logic [AMT_W-1:0] rem);
        logic [4:0] d;
        if (rem >= AMT_W'(7'd100)) begin
            d = 5'b10000;
        end else if (rem >= AMT_W'(6'd50)) begin
            d = 5'b01000;
        end else if (rem >= AMT_W'(5'd20)) begin
            d = 5'b00100;
        end else if (rem >= AMT_W'(4'd10)) begin
            d = 5'b00010;
        end else if (rem >= AMT_W'(3'd5)) begin
            d = 5'b00001;
        end else begin
            d = 5'b00000;
        end
        return d;
    endfunction

    // Quantity add that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [QTY_W-1:0] sat_add_qty(input logic [QTY_W-1:0] a,
                                                     input logic [QTY_W-1:0] b);
        logic [QTY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[QTY_W]) begin
            return {QTY_W{1'b1}};
        end else begin
            return s[QTY_W-1:0];
        end
    endfunction

    logic [2:0]               state_r, state_s;
    logic [AMT_W-1:0]         total_amount_r, total_amount_s;
    logic [AMT_W-1:0]         total_cost_r, total_cost_s;
    logic [AMT_W-1:0]         change_total_r, change_total_s;
    logic [AMT_W-1:0]         remain_r, remain_s;
    logic [TMR_W-1:0]         timer_r, timer_s;
    logic [QTY_W-1:0]         cart_r  [N_ITEMS];
    logic [QTY_W-1:0]         cart_s  [N_ITEMS];
    logic [QTY_W-1:0]         stock_r [N_ITEMS];
    logic [QTY_W-1:0]         stock_s [N_ITEMS];
    logic                     coin_reject_r, coin_reject_s;
    logic                     dispense_valid_r, dispense_valid_s;
    logic [N_ITEMS*QTY_W-1:0] dispense_qty_r, dispense_qty_s;
    logic                     note_valid_r, note_valid_s;
    logic [4:0]               note_denom_r, note_denom_s;
    logic                     is_refund_r, is_refund_s;
    logic                     busy_r, busy_s;

    logic [COST_W-1:0]        cost_s;
    logic                     over_stock_s;
    logic                     cart_zero_s;
    logic                     coin_onehot_s;
    logic [AMT_W:0]           coin_sum_s;
    logic [4:0]               pay_denom_s;

    // Cart evaluation: full-width cost, stock shortfall and empty-cart flags.
    always_comb begin
        cost_s       = '0;
        over_stock_s = 1'b0;
        cart_zero_s  = 1'b1;
        for (int i = 0; i < N_ITEMS; i++) begin
            cost_s = cost_s + (COST_W'(cart_r[i]) * COST_W'(PRICES[i*AMT_W +: AMT_W]));
            if (cart_r[i] > stock_r[i]) begin
                over_stock_s = 1'b1;
            end else begin
                over_stock_s = over_stock_s;
            end
            if (cart_r[i] != '0) begin
                cart_zero_s = 1'b0;
            end else begin
                cart_zero_s = cart_zero_s;
            end
        end
    end

    // Coin qualification helpers and the next note to pay out.
    always_comb begin
        coin_onehot_s = (coin != 5'b00000) && ((coin & (coin - 5'b00001)) == 5'b00000);
        coin_sum_s    = {1'b0, total_amount_r} + {1'b0, denom_value(coin)};
        pay_denom_s   = greedy_denom(remain_r);
    end

    // Next-state and next-output logic for the whole controller.
    always_comb begin
        state_s          = state_r;
        total_amount_s   = total_amount_r;
        total_cost_s     = total_cost_r;
        change_total_s   = change_total_r;
        remain_s         = remain_r;
        timer_s          = timer_r;
        coin_reject_s    = 1'b0;
        dispense_valid_s = 1'b0;
        dispense_qty_s   = '0;
        note_valid_s     = 1'b0;
        note_denom_s     = 5'b00000;
        is_refund_s      = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            cart_s[i]  = cart_r[i];
            stock_s[i] = stock_r[i];
        end

        // Coins count only in IDLE/SELECT, only one at a time, and never
        // past the accumulator range.
        if (coin != 5'b00000) begin
            if (coin_onehot_s && !coin_sum_s[AMT_W] &&
                ((state_r == ST_IDLE) || (state_r == ST_SELECT))) begin
                total_amount_s = coin_sum_s[AMT_W-1:0];
            end else begin
                coin_reject_s = 1'b1;
            end
        end else begin
            coin_reject_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (start && (total_amount_r != '0)) begin
                    state_s = ST_SELECT;
                    timer_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
                // An out-of-range index matches no item and is dropped.
                if (restock_valid) begin
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (restock_idx == IDX_W'(i)) begin
                            stock_s[i] = sat_add_qty(stock_r[i], restock_qty);
                        end else begin
                            stock_s[i] = stock_r[i];
                        end
                    end
                end else begin
                    state_s = state_s;
                end
            end

            ST_SELECT: begin
                if (add_more) begin
                    for (int i = 0; i < N_ITEMS; i++) begin
                        cart_s[i] = sat_add_qty(cart_r[i], sel_qty[i*QTY_W +: QTY_W]);
                    end
                end else begin
                    timer_s = timer_r;
                end
                // Refund uses total_amount_s so a coin landing this cycle
                // is returned as well.
                if (cancel) begin
                    state_s        = ST_REFUND;
                    remain_s       = total_amount_s;
                    change_total_s = total_amount_s;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        cart_s[i] = '0;
                    end
                end else if (confirm) begin
                    state_s = ST_CHECK;
                end else if (add_more || (coin != 5'b00000)) begin
                    timer_s = '0;
                end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                    state_s        = ST_REFUND;
                    remain_s       = total_amount_s;
                    change_total_s = total_amount_s;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        cart_s[i] = '0;
                    end
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end

            ST_CHECK: begin
                if (|cost_s[COST_W-1:AMT_W]) begin
                    total_cost_s = {AMT_W{1'b1}};
                end else begin
                    total_cost_s = cost_s[AMT_W-1:0];
                end
                for (int i = 0; i < N_ITEMS; i++) begin
                    cart_s[i] = '0;
                end
                if ((|cost_s[COST_W-1:AMT_W]) || (cost_s > COST_W'(total_amount_r)) ||
                    over_stock_s || cart_zero_s) begin
                    state_s        = ST_REFUND;
                    remain_s       = total_amount_r;
                    change_total_s = total_amount_r;
                end else begin
                    // Dispense outputs become visible while in DISPENSE.
                    state_s          = ST_DISPENSE;
                    dispense_valid_s = 1'b1;
                    change_total_s   = total_amount_r - cost_s[AMT_W-1:0];
                    remain_s         = total_amount_r - cost_s[AMT_W-1:0];
                    for (int i = 0; i < N_ITEMS; i++) begin
                        dispense_qty_s[i*QTY_W +: QTY_W] = cart_r[i];
                        stock_s[i] = stock_r[i] - cart_r[i];
                    end
                end
            end

            ST_DISPENSE: begin
                state_s = ST_CHANGE;
            end

            ST_CHANGE, ST_REFUND: begin
                // A remainder below the smallest note is treated as settled
                // so the payout can never stall.
                if (pay_denom_s == 5'b00000) begin
                    state_s        = ST_IDLE;
                    remain_s       = '0;
                    total_amount_s = '0;
                    total_cost_s   = '0;
                end else begin
                    note_valid_s = 1'b1;
                    note_denom_s = pay_denom_s;
                    is_refund_s  = (state_r == ST_REFUND);
                    remain_s     = remain_r - denom_value(pay_denom_s);
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            total_amount_r   <= '0;
            total_cost_r     <= '0;
            change_total_r   <= '0;
            remain_r         <= '0;
            timer_r          <= '0;
            coin_reject_r    <= 1'b0;
            dispense_valid_r <= 1'b0;
            dispense_qty_r   <= '0;
            note_valid_r     <= 1'b0;
            note_denom_r     <= 5'b00000;
            is_refund_r      <= 1'b0;
            busy_r           <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                cart_r[i]  <= '0;
                stock_r[i] <= QTY_W'(STOCK_INIT);
            end
        end else begin
            state_r          <= state_s;
            total_amount_r   <= total_amount_s;
            total_cost_r     <= total_cost_s;
            change_total_r   <= change_total_s;
            remain_r         <= remain_s;
            timer_r          <= timer_s;
            coin_reject_r    <= coin_reject_s;
            dispense_valid_r <= dispense_valid_s;
            dispense_qty_r   <= dispense_qty_s;
            note_valid_r     <= note_valid_s;
            note_denom_r     <= note_denom_s;
            is_refund_r      <= is_refund_s;
            busy_r           <= busy_s;
            for (int i = 0; i < N_ITEMS; i++) begin
                cart_r[i]  <= cart_s[i];
                stock_r[i] <= stock_s[i];
            end
        end
    end

    assign coin_reject    = coin_reject_r;
    assign total_amount   = total_amount_r;
    assign total_cost     = total_cost_r;
    assign dispense_valid = dispense_valid_r;
    assign dispense_qty   = dispense_qty_r;
    assign note_valid     = note_valid_r;
    assign note_denom     = note_denom_r;
    assign is_refund      = is_refund_r;
    assign change_total   = change_total_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_vending_ctrl_param
//   Directed self-checking bench for vending_ctrl_param (default prices,
//   STOCK_INIT = 2). Item prices: item0=20 item1=10 item2=5 item3=50 item4=100.
// ---------------------------------------------------------------------------
module tb_vending_ctrl_param;

    localparam int N_ITEMS = 5;
    localparam int QTY_W   = 4;
    localparam int AMT_W   = 16;

    localparam logic [4:0] C100 = 5'b10000;
    localparam logic [4:0] C50  = 5'b01000;
    localparam logic [4:0] C20  = 5'b00100;
    localparam logic [4:0] C10  = 5'b00010;

    logic                     clk;
    logic                     rst;
    logic [4:0]               coin;
    logic                     start;
    logic [N_ITEMS*QTY_W-1:0] sel_qty;
    logic                     add_more;
    logic                     confirm;
    logic                     cancel;
    logic                     restock_valid;
    logic [2:0]               restock_idx;
    logic [QTY_W-1:0]         restock_qty;
    logic                     coin_reject;
    logic [AMT_W-1:0]         total_amount;
    logic [AMT_W-1:0]         total_cost;
    logic                     dispense_valid;
    logic [N_ITEMS*QTY_W-1:0] dispense_qty;
    logic                     note_valid;
    logic [4:0]               note_denom;
    logic                     is_refund;
    logic [AMT_W-1:0]         change_total;
    logic                     busy;

    int n_total;
    int n_bad;

    // Observations gathered while a transaction runs to completion.
    int               disp_cnt;
    logic [19:0]      disp_qty_seen;
    logic [15:0]      cost_seen;
    int               note_cnt;
    int               refund_cnt;
    logic [19:0]      notes_pk;

    vending_ctrl_param #(
        .STOCK_INIT (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coin           (coin),
        .start          (start),
        .sel_qty        (sel_qty),
        .add_more       (add_more),
        .confirm        (confirm),
        .cancel         (cancel),
        .restock_valid  (restock_valid),
        .restock_idx    (restock_idx),
        .restock_qty    (restock_qty),
        .coin_reject    (coin_reject),
        .total_amount   (total_amount),
        .total_cost     (total_cost),
        .dispense_valid (dispense_valid),
        .dispense_qty   (dispense_qty),
        .note_valid     (note_valid),
        .note_denom     (note_denom),
        .is_refund      (is_refund),
        .change_total   (change_total),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [4:0] c);
        coin = c;
        tick();
        coin = 5'b00000;
    endtask

    // Run until the controller returns to IDLE, recording dispenses and notes.
    task automatic run_return(input string tag, input int budget);
        bit done;
        done          = 1'b0;
        disp_cnt      = 0;
        disp_qty_seen = '0;
        cost_seen     = '0;
        note_cnt      = 0;
        refund_cnt    = 0;
        notes_pk      = '0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (dispense_valid) begin
                disp_cnt++;
                disp_qty_seen = dispense_qty;
                cost_seen     = total_cost;
            end
            if (note_valid) begin
                note_cnt++;
                notes_pk = {notes_pk[14:0], note_denom};
                if (is_refund) refund_cnt++;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_reached_idle"}, 32'(done), 32'd1);
    endtask

    task automatic buy(input string tag, input logic [4:0] c, input logic [19:0] q, input bit split);
        put_coin(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        sel_qty  = q;
        add_more = 1'b1;
        confirm  = !split;
        tick();
        add_more = 1'b0;
        confirm  = 1'b0;
        if (split) begin
            confirm = 1'b1;
            tick();
            confirm = 1'b0;
        end
        sel_qty = '0;
        run_return(tag, 60);
    endtask

    task automatic restock(input logic [2:0] idx, input logic [3:0] q);
        restock_valid = 1'b1;
        restock_idx   = idx;
        restock_qty   = q;
        tick();
        restock_valid = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b0; coin = 5'b00000; start = 1'b0; sel_qty = '0;
        add_more = 1'b0; confirm = 1'b0; cancel = 1'b0;
        restock_valid = 1'b0; restock_idx = 3'd0; restock_qty = 4'd0;
        #23;
        chk("rst_total_amount", 32'(total_amount), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_note_valid", 32'(note_valid), 32'd0);
        chk("rst_dispense_valid", 32'(dispense_valid), 32'd0);
        chk("rst_change_total", 32'(change_total), 32'd0);
        rst = 1'b1;
        tick();

        // Start with no credit is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_credit_start", 32'(busy), 32'd0);

        // 1: pay 100 for item1 (10): change 50,20,20.
        put_coin(C100);
        chk("t1_credit", 32'(total_amount), 32'd100);
        chk("t1_no_reject", 32'(coin_reject), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        sel_qty = 20'h00010; add_more = 1'b1;
        tick();
        add_more = 1'b0; sel_qty = '0; confirm = 1'b1;
        tick();
        confirm = 1'b0;
        run_return("t1", 60);
        chk("t1_disp_cnt", 32'(disp_cnt), 32'd1);
        chk("t1_disp_qty", 32'(disp_qty_seen), 32'h00010);
        chk("t1_cost", 32'(cost_seen), 32'd10);
        chk("t1_notes", 32'(notes_pk), 32'({C50, C20, C20}));
        chk("t1_note_cnt", 32'(note_cnt), 32'd3);
        chk("t1_refunds", 32'(refund_cnt), 32'd0);
        chk("t1_change_total", 32'(change_total), 32'd90);
        chk("t1_amount_cleared", 32'(total_amount), 32'd0);

        // 2: item3 x2 costs 100 with only 50 in: refund one 50.
        buy("t2", C50, 20'h02000, 1'b1);
        chk("t2_disp_cnt", 32'(disp_cnt), 32'd0);
        chk("t2_notes", 32'(notes_pk), 32'(C50));
        chk("t2_refunds", 32'(refund_cnt), 32'd1);
        chk("t2_change_total", 32'(change_total), 32'd50);

        // Cancel in SELECT refunds the credit.
        put_coin(C10);
        start = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b1;
        tick();
        cancel = 1'b0;
        run_return("cancel", 20);
        chk("cancel_notes", 32'(notes_pk), 32'(C10));
        chk("cancel_refunds", 32'(refund_cnt), 32'd1);

        // 3: inactivity timeout refunds 20.
        put_coin(C20);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) tick();
        chk("t3_still_select", 32'(busy), 32'd1);
        chk("t3_no_early_note", 32'(note_valid), 32'd0);
        run_return("t3", 40);
        chk("t3_notes", 32'(notes_pk), 32'(C20));
        chk("t3_refunds", 32'(refund_cnt), 32'd1);
        chk("t3_busy_low", 32'(busy), 32'd0);

        // 4: item0 x3 exceeds stock 2 -> refund; restock +5 -> buy 3, stock 4.
        buy("t4a", C100, 20'h00003, 1'b0);
        chk("t4a_disp_cnt", 32'(disp_cnt), 32'd0);
        chk("t4a_notes", 32'(notes_pk), 32'(C100));
        restock(3'd7, 4'd15);
        restock(3'd0, 4'd5);
        buy("t4b", C100, 20'h00003, 1'b0);
        chk("t4b_disp_qty", 32'(disp_qty_seen), 32'h00003);
        chk("t4b_cost", 32'(cost_seen), 32'd60);
        chk("t4b_notes", 32'(notes_pk), 32'({C20, C20}));
        buy("t4c", C100, 20'h00004, 1'b0);
        chk("t4c_disp_qty", 32'(disp_qty_seen), 32'h00004);
        chk("t4c_notes", 32'(notes_pk), 32'(C20));
        buy("t4d", C20, 20'h00001, 1'b0);
        chk("t4d_disp_cnt", 32'(disp_cnt), 32'd0);
        chk("t4d_refunds", 32'(refund_cnt), 32'd1);

        // 5: two coins at once rejected; exact pay for item0 gives no notes.
        put_coin(5'b11000);
        chk("t5_reject", 32'(coin_reject), 32'd1);
        chk("t5_amount_kept", 32'(total_amount), 32'd0);
        tick();
        chk("t5_reject_pulse", 32'(coin_reject), 32'd0);
        restock(3'd0, 4'd1);
        buy("t5", C20, 20'h00001, 1'b0);
        chk("t5_disp_qty", 32'(disp_qty_seen), 32'h00001);
        chk("t5_cost", 32'(cost_seen), 32'd20);
        chk("t5_note_cnt", 32'(note_cnt), 32'd0);
        chk("t5_change_total", 32'(change_total), 32'd0);

        // 6: reset during CHANGE after the first note.
        put_coin(C100);
        start = 1'b1;
        tick();
        start = 1'b0; sel_qty = 20'h00010; add_more = 1'b1; confirm = 1'b1;
        tick();
        add_more = 1'b0; confirm = 1'b0; sel_qty = '0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (note_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t6_first_note", 32'(seen), 32'd1);
        end
        rst = 1'b0;
        #1;
        chk("t6_rst_note", 32'(note_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_amount", 32'(total_amount), 32'd0);
        chk("t6_rst_change", 32'(change_total), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("t6_idle", 32'(busy), 32'd0);
        // item0 stock was 0 before reset; 2 units now proves it was restored.
        buy("t6", C50, 20'h00002, 1'b0);
        chk("t6_disp_qty", 32'(disp_qty_seen), 32'h00002);
        chk("t6_notes", 32'(notes_pk), 32'(C10));
        chk("t6_change_total", 32'(change_total), 32'd10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
